// File: rtl/he_pkg.sv
// Shared definitions for the histogram-equalisation LUT generator:
// the top-level state encoding and the width helpers.
package he_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        SCAN,
        MAP,
        OUT
    } he_state_e;

    function automatic int calc_lut_len(input int pix_w);
        return 1 << pix_w;
    endfunction

    function automatic int calc_cnt_w(input int num_pixels);
        return $clog2(num_pixels + 1);
    endfunction

endpackage

// File: rtl/he_div_serial.sv
// Restoring unsigned divider, one quotient bit per cycle. The caller guarantees
// the quotient fits in Q_W bits, i.e. (dividend >> Q_W) < divisor.
module he_div_serial #(
    parameter int DVD_W = 24,
    parameter int DVS_W = 16,
    parameter int Q_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int CW = (Q_W > 1) ? $clog2(Q_W) : 1;

    logic [DVS_W-1:0] rem_q, rem_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [Q_W-1:0]   q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DVS_W:0]   rem_sh;
    logic [DVS_W-1:0] diff;
    logic             ge;

    // Low dividend bits and the quotient share one shift register.
    always_comb begin
        rem_sh = {rem_q, q_q[Q_W-1]};
        diff   = rem_sh[DVS_W-1:0] - dvs_q;
        ge     = (rem_sh >= {1'b0, dvs_q});
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            rem_d  = dividend[DVD_W-1 -: DVS_W];
            q_d    = dividend[Q_W-1:0];
            dvs_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = ge ? diff : rem_sh[DVS_W-1:0];
            q_d   = {q_q[Q_W-2:0], ge};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(Q_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        dvs_q <= dvs_d;
        q_q   <= q_d;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = q_q;

endmodule

// File: rtl/he_lut_gen.sv
// Histogram-equalisation engine: histogram -> normalised CDF table, streamed out in index order.
// Optional macro HE_CLIP_EN clips every bin at CLIP_LIMIT before the CDF is formed.
module he_lut_gen
    import he_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int IMG_W      = 660,
    parameter int IMG_H      = 440,
    parameter int CLIP_LIMIT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PIX_W-1:0] pixel_value,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [PIX_W-1:0] lut_index,
    output logic [PIX_W-1:0] transformed_pixel,
    output logic             lut_valid,
    input  logic             lut_ready,
    output logic             busy,
    output logic             done
);

    localparam int L          = calc_lut_len(PIX_W);
    localparam int NUM_PIXELS = IMG_W * IMG_H;
    localparam int CNT_W      = calc_cnt_w(NUM_PIXELS);
    localparam int BIN_W      = (CNT_W > PIX_W) ? CNT_W : PIX_W;
    localparam int PROD_W     = CNT_W + PIX_W;
    localparam int IDX_W      = PIX_W + 1;

    if (PIX_W < 2 || CLIP_LIMIT < 1) begin : g_param_check
        $error("he_lut_gen: PIX_W must be >= 2 and CLIP_LIMIT >= 1");
    end

    function automatic logic [CNT_W-1:0] clip_bin(input logic [CNT_W-1:0] v);
`ifdef HE_CLIP_EN
        if (32'(v) > CLIP_LIMIT) return CNT_W'(CLIP_LIMIT);
        return v;
`else
        return v;
`endif
    endfunction

    // Bins hold counts until MAP overwrites each one with its table value.
    logic [BIN_W-1:0] bins_q [L];
    logic [BIN_W-1:0] rd_data_q, rd_val, wr_data, wr_data_q;
    logic [PIX_W-1:0] rd_addr, rd_addr_q, wr_addr, wr_addr_q;
    logic             wr_en, wr_vld_q;

    he_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] cdf_q, cdf_d, cdf_max_q, cdf_max_d, cdf_min_q, cdf_min_d;
    logic             acc_vld_q, acc_vld_d, map_wait_q, map_wait_d;
    logic             lut_valid_q, lut_valid_d, done_q, done_d;
    logic [PIX_W-1:0] lut_index_q, lut_index_d, xfm_q, xfm_d;
    logic [CNT_W-1:0] b_val, cdf_n;
    logic             accept, load;

    logic              div_start, div_busy, div_done;
    logic [PROD_W-1:0] div_dividend;
    logic [CNT_W-1:0]  div_divisor;
    logic [PIX_W-1:0]  div_quot;

    he_div_serial #(
        .DVD_W(PROD_W),
        .DVS_W(CNT_W),
        .Q_W  (PIX_W)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .start   (div_start),
        .dividend(div_dividend),
        .divisor (div_divisor),
        .busy    (div_busy),
        .done    (div_done),
        .quotient(div_quot)
    );

    // Registered read; a write landing on the address just read is forwarded.
    assign rd_val = (wr_vld_q && (wr_addr_q == rd_addr_q)) ? wr_data_q : rd_data_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pix_cnt_d    = pix_cnt_q;
        cdf_d        = cdf_q;
        cdf_max_d    = cdf_max_q;
        cdf_min_d    = cdf_min_q;
        map_wait_d   = map_wait_q;
        lut_valid_d  = lut_valid_q;
        lut_index_d  = lut_index_q;
        xfm_d        = xfm_q;
        done_d       = 1'b0;
        acc_vld_d    = 1'b0;
        div_start    = 1'b0;
        load         = 1'b0;
        rd_addr      = '0;
        pix_ready    = (state_q == ACCUM);
        accept       = pix_valid && pix_ready;
        b_val        = clip_bin(rd_val[CNT_W-1:0]);
        cdf_n        = cdf_q + b_val;
        div_dividend = PROD_W'(cdf_n - cdf_min_q) * PROD_W'(L - 1);
        div_divisor  = cdf_max_q - cdf_min_q;
        wr_en        = acc_vld_q;
        wr_addr      = rd_addr_q;
        wr_data      = rd_val + BIN_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CLEAR;
                    idx_d     = '0;
                    pix_cnt_d = '0;
                end
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = idx_q[PIX_W-1:0];
                wr_data = '0;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(L - 1)) state_d = ACCUM;
            end
            ACCUM: begin
                rd_addr = pixel_value;
                if (accept) begin
                    acc_vld_d = 1'b1;
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    if (pix_cnt_q == CNT_W'(NUM_PIXELS - 1)) begin
                        state_d   = SCAN;
                        idx_d     = '0;
                        cdf_max_d = '0;
                        cdf_min_d = '0;
                    end
                end
            end
            SCAN: begin
                // Data for bin idx-1 arrives while bin idx is being read.
                rd_addr = idx_q[PIX_W-1:0];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q != '0) begin
                    cdf_max_d = cdf_max_q + b_val;
                    if (cdf_min_q == '0 && b_val != '0) cdf_min_d = b_val;
                end
                if (idx_q == IDX_W'(L)) begin
                    state_d    = MAP;
                    idx_d      = '0;
                    cdf_d      = '0;
                    map_wait_d = 1'b0;
                end
            end
            MAP: begin
                if (!map_wait_q) begin
                    cdf_d = cdf_n;
                    if (cdf_max_q == cdf_min_q) begin
                        wr_en   = 1'b1;
                        wr_addr = idx_q[PIX_W-1:0];
                        wr_data = BIN_W'(idx_q[PIX_W-1:0]);
                    end else if (cdf_n <= cdf_min_q) begin
                        wr_en   = 1'b1;
                        wr_addr = idx_q[PIX_W-1:0];
                        wr_data = '0;
                    end else begin
                        div_start  = 1'b1;
                        map_wait_d = 1'b1;
                    end
                end else if (div_done && !div_busy) begin
                    wr_en      = 1'b1;
                    wr_addr    = idx_q[PIX_W-1:0];
                    wr_data    = BIN_W'(div_quot);
                    map_wait_d = 1'b0;
                end
                if (wr_en) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(L - 1)) begin
                        state_d = OUT;
                        idx_d   = '0;
                    end
                end
                rd_addr = idx_d[PIX_W-1:0];
            end
            OUT: begin
                load = (idx_q < IDX_W'(L)) && (!lut_valid_q || lut_ready);
                if (lut_valid_q && lut_ready) begin
                    lut_valid_d = 1'b0;
                    if (lut_index_q == PIX_W'(L - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                if (load) begin
                    lut_valid_d = 1'b1;
                    lut_index_d = idx_q[PIX_W-1:0];
                    xfm_d       = rd_val[PIX_W-1:0];
                    idx_d       = idx_q + IDX_W'(1);
                end
                rd_addr = idx_d[PIX_W-1:0];
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_vld_q   <= 1'b0;
            wr_vld_q    <= 1'b0;
            map_wait_q  <= 1'b0;
            lut_valid_q <= 1'b0;
            lut_index_q <= '0;
            xfm_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_vld_q   <= acc_vld_d;
            wr_vld_q    <= wr_en;
            map_wait_q  <= map_wait_d;
            lut_valid_q <= lut_valid_d;
            lut_index_q <= lut_index_d;
            xfm_q       <= xfm_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q     <= idx_d;
        pix_cnt_q <= pix_cnt_d;
        cdf_q     <= cdf_d;
        cdf_max_q <= cdf_max_d;
        cdf_min_q <= cdf_min_d;
        rd_data_q <= bins_q[rd_addr];
        rd_addr_q <= rd_addr;
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
        if (wr_en) bins_q[wr_addr] <= wr_data;
    end

    assign lut_valid         = lut_valid_q;
    assign lut_index         = lut_index_q;
    assign transformed_pixel = xfm_q;
    assign busy              = (state_q != IDLE);
    assign done              = done_q;

endmodule

// File: doc/he_lut_gen.md
# he_lut_gen

Parametrised histogram-equalisation engine, successor to the fixed 8-bit / 660x440 HE block. It accepts one frame of pixels over a valid/ready stream and builds a 2^PIX_W-bin histogram. It then computes the normalised-CDF transform table and streams the table out over a valid/ready handshake to the downstream remapper, in index order 0..L-1.

## Interface
- PIX_W, 8, pixel bit width; L = 2^PIX_W bins/table entries
- IMG_W, 660, frame width in pixels
- IMG_H, 440, frame height; NUM_PIXELS = IMG_W*IMG_H
- CLIP_LIMIT, 4096, per-bin clip level (used only with HE_CLIP_EN)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  begin new frame; sampled only in IDLE
- pixel_value  in  PIX_W  input pixel
- pix_valid  in  1  pixel_value valid
- pix_ready  out  1  high only in ACCUM
- lut_index  out  PIX_W  table index of current output entry
- transformed_pixel  out  PIX_W  table value for lut_index
- lut_valid  out  1  output entry valid
- lut_ready  in  1  downstream accepts entry
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after final table entry is accepted

## Operation
- CNT_W = $clog2(NUM_PIXELS+1) for bins, CDF, and pixel counter. Product width is CNT_W+PIX_W.
- IDLE -> CLEAR on start. CLEAR zeroes bins 0..L-1, one per cycle (L cycles), then goes to ACCUM.
- ACCUM: every cycle with pix_valid & pix_ready increments bin[pixel_value] by exactly 1. This includes back-to-back identical pixels, so read-modify-write forwarding is mandatory. After NUM_PIXELS accepts, pix_ready drops the next cycle and the state goes to SCAN. Extra pix_valid is ignored.
- SCAN: pass over bins 0..L-1 with b[k] = bin[k] (clipped, see Configuration).
  - cdf_max = sum of b[k].
  - cdf_min = first nonzero b[k].
- MAP: for k = 0..L-1, keep a running cdf += b[k] and write bin[k] <- LUT[k] in place.
  - cdf <= cdf_min -> LUT[k] = 0.
  - cdf_max == cdf_min (single-valued frame) -> LUT[k] = k (identity).
  - Otherwise LUT[k] = floor((cdf-cdf_min)*(L-1) / (cdf_max-cdf_min)). The result is always < L.
- OUT: present entries k = 0..L-1 in order. Entry k advances on lut_valid & lut_ready. After entry L-1 is accepted, pulse done and return to IDLE.
- start outside IDLE is ignored.
- reset in any state: return to IDLE. Histogram contents are don't-care because CLEAR precedes every frame.

## Timing
- Reset values: pix_ready=0, lut_valid=0, lut_index=0, transformed_pixel=0, busy=0, done=0.
- start -> pix_ready high: L+1 cycles.
- ACCUM throughput: 1 pixel/cycle. Gaps in pix_valid stall without loss.
- SCAN: L+1 cycles.
- MAP: at most L*(PIX_W+2) cycles. The serial divider produces 1 quotient bit per cycle.
- OUT: lut_valid is registered. lut_index and transformed_pixel hold stable while lut_valid & !lut_ready. Minimum L cycles with lut_ready held high.
- done: asserted the cycle after the final handshake. busy falls in the same cycle.

## Configuration
- HE_CLIP_EN defined: b[k] = min(bin[k], CLIP_LIMIT) in both SCAN and MAP. Excess counts are discarded (no redistribution). cdf_max is the clipped total.
- HE_CLIP_EN undefined: b[k] = bin[k], cdf_max = NUM_PIXELS, the CLIP_LIMIT parameter is unused, and no clip comparator is synthesised.

## Structure
- Shared package he_pkg:
  - state enum (IDLE, CLEAR, ACCUM, SCAN, MAP, OUT)
  - functions for CNT_W and L
- Sub-module he_div_serial: restoring unsigned divider with start/busy/quotient.
  - Dividend width CNT_W+PIX_W, divisor width CNT_W, quotient width PIX_W.
  - Used once per bin in MAP.

## Test plan
- Reset held for 10 cycles mid-OUT -> all outputs 0, busy=0. A following start runs a full frame normally.
- IMG 4x4, 8 pixels of 10 and 8 pixels of 200 -> LUT[0..199]=0, LUT[200..255]=255, done once after index 255.
- IMG 4x4, pixels 0..15 once each -> LUT[k]=17k for k<=15, LUT[16..255]=255.
- IMG 4x4, all pixels 77 -> identity table, LUT[k]=k for all k.
- lut_ready toggling every cycle plus random pix_valid gaps -> 256 entries in order, no duplicates or drops, values equal to the ungated run.
- HE_CLIP_EN, CLIP_LIMIT=4, IMG 4x4, 12 pixels of 5 and 4 pixels of 9 -> cdf_min=4, cdf_max=8, LUT[0..8]=0, LUT[9..255]=255.
